// File: rtl/mips_io_port.sv
// Memory-mapped I/O port for a MIPS data bus: a 4-deep output FIFO toward an external
// sink and a single-byte 4-phase handshake input register, with a status word.
module mips_io_port #(
    parameter logic [31:0] ADDR_OUT  = 32'h1001_0024,
    parameter logic [31:0] ADDR_IN   = 32'h1001_0028,
    parameter logic [31:0] ADDR_STAT = 32'h1001_002C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic [31:0] PortOut,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  PortIn,
    input  logic        in_strobe,
    output logic        in_ack
);

    typedef enum logic [1:0] {IDLE, ACK, HELD, ACK_EMPTY} in_state_t;

    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        overflow;
    logic        out_full;
    logic        push_req, push, pop, ovf_event;
    logic        in_rd, stat_rd;

    in_state_t   state, state_next;
    logic [7:0]  in_data;
    logic        in_full;
    logic        capture;

    assign out_full  = (count == 3'd4);
    assign out_valid = (count != 3'd0);
    assign PortOut   = out_valid ? mem[rd_ptr] : '0;

    assign push_req  = MemWrite && (Address == ADDR_OUT);
    assign pop       = out_valid && out_ready;
    // A pop frees the slot in the same edge, so a push at full still lands.
    assign push      = push_req && (!out_full || pop);
    assign ovf_event = push_req && out_full && !pop;

    assign in_rd     = MemRead && (Address == ADDR_IN);
    assign stat_rd   = MemRead && (Address == ADDR_STAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= WriteData;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (ovf_event)    overflow <= 1'b1;
            else if (stat_rd) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            in_data <= '0;
        end else begin
            state <= state_next;
            if (capture) in_data <= PortIn;
        end
    end

    always_comb begin
        state_next = state;
        in_ack     = 1'b0;
        in_full    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (in_strobe) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                in_ack  = 1'b1;
                in_full = 1'b1;
                if (in_rd)           state_next = in_strobe ? ACK_EMPTY : IDLE;
                else if (!in_strobe) state_next = HELD;
            end
            HELD: begin
                in_full = 1'b1;
                if (in_rd) state_next = IDLE;
            end
            ACK_EMPTY: begin
                in_ack = 1'b1;
                if (!in_strobe) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ReadData = '0;
        if (in_rd)        ReadData = {24'b0, in_data};
        else if (stat_rd) ReadData = {26'b0, overflow, in_full, out_full, count};
    end

endmodule

// File: tb/tb_mips_io_port.sv
// Self-checking bench for mips_io_port: directed scenarios with literal expectations,
// then random bus/handshake traffic compared every cycle against a queue-based model.
module tb_mips_io_port;

    localparam logic [31:0] A_OUT  = 32'h1001_0024;
    localparam logic [31:0] A_IN   = 32'h1001_0028;
    localparam logic [31:0] A_STAT = 32'h1001_002C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic [31:0] PortOut;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  PortIn = '0;
    logic        in_strobe = 1'b0;
    logic        in_ack;

    int checks = 0;
    int failures = 0;

    mips_io_port #(.ADDR_OUT(A_OUT), .ADDR_IN(A_IN), .ADDR_STAT(A_STAT)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .PortOut(PortOut), .out_valid(out_valid), .out_ready(out_ready),
        .PortIn(PortIn), .in_strobe(in_strobe), .in_ack(in_ack)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue; input side as "byte unread" and "ack raised" flags.
    logic [31:0] q[$];
    logic        m_ovf;
    logic        m_full;
    logic        m_ack;
    logic [7:0]  m_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovf  <= 1'b0;
            m_full <= 1'b0;
            m_ack  <= 1'b0;
            m_data <= '0;
        end else begin
            bit pop_now, wr_out, rd_in, rd_stat, ovf_now, cap;
            pop_now = (q.size() != 0) && out_ready;
            wr_out  = MemWrite && (Address == A_OUT);
            rd_in   = MemRead && (Address == A_IN);
            rd_stat = MemRead && (Address == A_STAT);
            ovf_now = 1'b0;
            if (pop_now) void'(q.pop_front());
            if (wr_out) begin
                if (q.size() < 4) q.push_back(WriteData);
                else ovf_now = 1'b1;
            end
            m_ovf <= ovf_now ? 1'b1 : (rd_stat ? 1'b0 : m_ovf);
            cap = !m_full && !m_ack && in_strobe;
            if (cap) m_data <= PortIn;
            m_full <= cap ? 1'b1 : ((rd_in && m_full) ? 1'b0 : m_full);
            m_ack  <= m_ack ? in_strobe : cap;
        end
    end

    function automatic logic [31:0] exp_rd();
        logic [2:0] n;
        n = 3'(q.size());
        if (!MemRead) return '0;
        if (Address == A_IN) return {24'b0, m_data};
        if (Address == A_STAT) return {26'b0, m_ovf, m_full, (n == 3'd4), n};
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("model_PortOut", PortOut, (q.size() != 0) ? q[0] : 32'h0);
        chk("model_in_ack", 32'(in_ack), 32'(m_ack));
        chk("model_ReadData", ReadData, exp_rd());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        Address  = '0;
    endtask

    task automatic store(input logic [31:0] v);
        MemWrite = 1'b1; Address = A_OUT; WriteData = v;
        tick();
        idle_bus();
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1; Address = a;
        @(negedge clk);
        chk(name, ReadData, exp);
    endtask

    initial begin
        // Reset: asserted at t=0, released at 7 ns.
        #7 reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ack", 32'(in_ack), 32'h0);
        peek("rst_status", A_STAT, 32'h0);
        tick(); idle_bus();

        // Fill with overflow, then drain.
        for (int i = 1; i <= 5; i++) store(32'(i));
        peek("fill_status", A_STAT, 32'h2C);
        tick(); idle_bus();
        peek("status_after_clear", A_STAT, 32'h0C);
        tick(); idle_bus();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_PortOut", PortOut, 32'(i));
            tick();
        end
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        tick();

        // Simultaneous push and pop at full.
        for (int i = 10; i <= 13; i++) store(32'(i));
        out_ready = 1'b1;
        MemWrite = 1'b1; Address = A_OUT; WriteData = 32'd9;
        tick(); idle_bus();
        out_ready = 1'b0;
        peek("pushpop_status", A_STAT, 32'h0C);
        tick(); idle_bus();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = (i == 3) ? 32'd9 : 32'(11 + i);
            @(negedge clk);
            chk("pushpop_order", PortOut, e);
            tick();
        end
        out_ready = 1'b0;

        // Input handshake and held-data protection.
        PortIn = 8'd3; in_strobe = 1'b1;
        tick();
        @(negedge clk);
        chk("hs_ack", 32'(in_ack), 32'h1);
        in_strobe = 1'b0;
        tick();
        @(negedge clk);
        chk("held_ack", 32'(in_ack), 32'h0);
        PortIn = 8'h55; in_strobe = 1'b1;
        tick();
        @(negedge clk);
        chk("held_no_ack", 32'(in_ack), 32'h0);
        peek("held_read", A_IN, 32'h3);
        tick(); idle_bus();
        tick();
        @(negedge clk);
        chk("recapture_ack", 32'(in_ack), 32'h1);
        peek("recapture_read", A_IN, 32'h55);
        tick(); idle_bus();
        @(negedge clk);
        chk("ack_empty_ack", 32'(in_ack), 32'h1);
        peek("ack_empty_status", A_STAT, 32'h0);
        idle_bus();
        in_strobe = 1'b0;
        tick();

        // Asynchronous reset mid-transfer.
        store(32'hA);
        store(32'hB);
        PortIn = 8'h77; in_strobe = 1'b1;
        tick();
        @(negedge clk);
        chk("pre_rst_ack", 32'(in_ack), 32'h1);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        in_strobe = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_ack", 32'(in_ack), 32'h0);
        chk("async_PortOut", PortOut, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        peek("post_rst_in", A_IN, 32'h0);
        idle_bus();
        PortIn = 8'h42; in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        peek("post_rst_capture", A_IN, 32'h42);
        tick(); idle_bus();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            int unsigned sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0: Address = A_OUT;
                1: Address = A_IN;
                2: Address = A_STAT;
                3: Address = A_OUT;
                default: Address = $urandom;
            endcase
            WriteData = $urandom;
            MemWrite  = ($urandom_range(0, 2) != 0);
            MemRead   = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            in_strobe = ($urandom_range(0, 1) != 0);
            PortIn    = 8'($urandom);
            if (c % 997 == 500) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end
        idle_bus();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
